// File: rtl/draw_scheduler.sv
// Draw command scheduler: FIFO of fill/line/symbol/swap commands executed one at a time,
// with a grant-based frame buffer write mux. Optional macro: DRAW_SCHEDULER_COLLISION_EN.
module draw_scheduler #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int SYMBOL_WIDTH      = 7,
    parameter int FIFO_DEPTH        = 8,
    parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    parameter int ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [X_WIDTH-1:0]      cmd_x1,
    input  logic [X_WIDTH-1:0]      cmd_x2,
    input  logic [Y_WIDTH-1:0]      cmd_y1,
    input  logic [Y_WIDTH-1:0]      cmd_y2,
    input  logic [SYMBOL_WIDTH-1:0] cmd_symbol,
    input  logic                    cmd_cursor_left,
    input  logic                    cmd_cursor_right,
    output logic                    line_start,
    output logic                    symbol_start,
    output logic                    fill_start,
    input  logic                    line_ready,
    input  logic                    symbol_ready,
    input  logic                    fill_ready,
    output logic [X_WIDTH-1:0]      line_x1,
    output logic [Y_WIDTH-1:0]      line_y1,
    output logic [X_WIDTH-1:0]      line_x2,
    output logic [Y_WIDTH-1:0]      line_y2,
    output logic [X_WIDTH-1:0]      symbol_x,
    output logic [Y_WIDTH-1:0]      symbol_y,
    output logic [SYMBOL_WIDTH-1:0] symbol_symbol,
    output logic                    symbol_cursor_left,
    output logic                    symbol_cursor_right,
    input  logic                    line_write_enable,
    input  logic [ADDR_WIDTH-1:0]   line_write_addr,
    input  logic                    line_write_data,
    input  logic                    symbol_write_enable,
    input  logic [ADDR_WIDTH-1:0]   symbol_write_addr,
    input  logic                    symbol_write_data,
    input  logic                    fill_write_enable,
    input  logic [ADDR_WIDTH-1:0]   fill_write_addr,
    input  logic                    fill_write_data,
    output logic                    fb_write_enable,
    output logic [ADDR_WIDTH-1:0]   fb_write_addr,
    output logic                    fb_write_data,
    output logic                    swap,
    output logic                    idle,
    output logic                    collision
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_FILL   = 2'd0;
    localparam logic [1:0] OP_LINE   = 2'd1;
    localparam logic [1:0] OP_SYMBOL = 2'd2;
    localparam logic [1:0] OP_SWAP   = 2'd3;

    typedef struct packed {
        logic [1:0]              op;
        logic [X_WIDTH-1:0]      x1;
        logic [X_WIDTH-1:0]      x2;
        logic [Y_WIDTH-1:0]      y1;
        logic [Y_WIDTH-1:0]      y2;
        logic [SYMBOL_WIDTH-1:0] symbol;
        logic                    cursor_left;
        logic                    cursor_right;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_BUSY     = 3'd3,
        ST_SWAPWAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        G_NONE   = 2'd0,
        G_FILL   = 2'd1,
        G_LINE   = 2'd2,
        G_SYMBOL = 2'd3
    } grant_t;

    cmd_t             fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    state_t state_q;
    grant_t grant_q;

    logic                    fill_start_q;
    logic                    line_start_q;
    logic                    symbol_start_q;
    logic                    swap_q;
    logic [X_WIDTH-1:0]      line_x1_q;
    logic [Y_WIDTH-1:0]      line_y1_q;
    logic [X_WIDTH-1:0]      line_x2_q;
    logic [Y_WIDTH-1:0]      line_y2_q;
    logic [X_WIDTH-1:0]      symbol_x_q;
    logic [Y_WIDTH-1:0]      symbol_y_q;
    logic [SYMBOL_WIDTH-1:0] symbol_symbol_q;
    logic                    symbol_cursor_left_q;
    logic                    symbol_cursor_right_q;

    cmd_t cmd_in_s;
    cmd_t head_s;
    logic empty_s;
    logic full_s;
    logic push_s;
    logic pop_s;
    logic tgt_ready_s;
    logic all_ready_s;

    assign cmd_in_s = {cmd_op, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_symbol,
                       cmd_cursor_left, cmd_cursor_right};
    assign head_s   = fifo_mem_q[rd_ptr_q];

    // Full/empty come only from the registered occupancy count, so cmd_ready never depends on a pop.
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    assign cmd_ready = ~full_s;
    assign push_s    = cmd_valid & ~full_s;
    assign pop_s     = (state_q == ST_IDLE) & ~empty_s;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Command storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= cmd_in_s;
        end
    end

    // FIFO pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Ready of the drawer currently owning the grant.
    always_comb begin
        tgt_ready_s = 1'b1;
        case (grant_q)
            G_FILL:   tgt_ready_s = fill_ready;
            G_LINE:   tgt_ready_s = line_ready;
            G_SYMBOL: tgt_ready_s = symbol_ready;
            default:  tgt_ready_s = 1'b1;
        endcase
    end

    assign all_ready_s = fill_ready & line_ready & symbol_ready;

    // Sequencer: pops one command, launches its drawer and waits for it to finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= ST_IDLE;
            grant_q               <= G_NONE;
            fill_start_q          <= 1'b0;
            line_start_q          <= 1'b0;
            symbol_start_q        <= 1'b0;
            swap_q                <= 1'b0;
            line_x1_q             <= {X_WIDTH{1'b0}};
            line_y1_q             <= {Y_WIDTH{1'b0}};
            line_x2_q             <= {X_WIDTH{1'b0}};
            line_y2_q             <= {Y_WIDTH{1'b0}};
            symbol_x_q            <= {X_WIDTH{1'b0}};
            symbol_y_q            <= {Y_WIDTH{1'b0}};
            symbol_symbol_q       <= {SYMBOL_WIDTH{1'b0}};
            symbol_cursor_left_q  <= 1'b0;
            symbol_cursor_right_q <= 1'b0;
        end else begin
            fill_start_q   <= 1'b0;
            line_start_q   <= 1'b0;
            symbol_start_q <= 1'b0;
            swap_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        line_x1_q             <= head_s.x1;
                        line_y1_q             <= head_s.y1;
                        line_x2_q             <= head_s.x2;
                        line_y2_q             <= head_s.y2;
                        symbol_x_q            <= head_s.x1;
                        symbol_y_q            <= head_s.y1;
                        symbol_symbol_q       <= head_s.symbol;
                        symbol_cursor_left_q  <= head_s.cursor_left;
                        symbol_cursor_right_q <= head_s.cursor_right;
                        case (head_s.op)
                            OP_FILL: begin
                                grant_q <= G_FILL;
                                state_q <= ST_LAUNCH;
                            end
                            OP_LINE: begin
                                grant_q <= G_LINE;
                                state_q <= ST_LAUNCH;
                            end
                            OP_SYMBOL: begin
                                grant_q <= G_SYMBOL;
                                state_q <= ST_LAUNCH;
                            end
                            OP_SWAP: begin
                                grant_q <= G_NONE;
                                state_q <= ST_SWAPWAIT;
                            end
                            default: begin
                                grant_q <= G_NONE;
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_LAUNCH: begin
                    if (tgt_ready_s) begin
                        case (grant_q)
                            G_FILL:   fill_start_q   <= 1'b1;
                            G_LINE:   line_start_q   <= 1'b1;
                            G_SYMBOL: symbol_start_q <= 1'b1;
                            default:  fill_start_q   <= 1'b0;
                        endcase
                        state_q <= ST_SETTLE;
                    end
                end
                // Drawer still shows ready this cycle; it drops only after seeing start.
                ST_SETTLE: begin
                    state_q <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (tgt_ready_s) begin
                        grant_q <= G_NONE;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SWAPWAIT: begin
                    if (all_ready_s) begin
                        swap_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= G_NONE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Frame buffer write port follows the granted drawer only.
    always_comb begin
        fb_write_enable = 1'b0;
        fb_write_addr   = {ADDR_WIDTH{1'b0}};
        fb_write_data   = 1'b0;
        case (grant_q)
            G_FILL: begin
                fb_write_enable = fill_write_enable;
                fb_write_addr   = fill_write_addr;
                fb_write_data   = fill_write_data;
            end
            G_LINE: begin
                fb_write_enable = line_write_enable;
                fb_write_addr   = line_write_addr;
                fb_write_data   = line_write_data;
            end
            G_SYMBOL: begin
                fb_write_enable = symbol_write_enable;
                fb_write_addr   = symbol_write_addr;
                fb_write_data   = symbol_write_data;
            end
            default: begin
                fb_write_enable = 1'b0;
                fb_write_addr   = {ADDR_WIDTH{1'b0}};
                fb_write_data   = 1'b0;
            end
        endcase
    end

`ifdef DRAW_SCHEDULER_COLLISION_EN
    logic foreign_we_s;
    logic collision_q;

    // A write attempt from any drawer not holding the grant.
    always_comb begin
        foreign_we_s = 1'b0;
        case (grant_q)
            G_FILL:   foreign_we_s = line_write_enable | symbol_write_enable;
            G_LINE:   foreign_we_s = fill_write_enable | symbol_write_enable;
            G_SYMBOL: foreign_we_s = fill_write_enable | line_write_enable;
            default:  foreign_we_s = fill_write_enable | line_write_enable | symbol_write_enable;
        endcase
    end

    // Sticky until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_q | foreign_we_s;
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

    assign fill_start          = fill_start_q;
    assign line_start          = line_start_q;
    assign symbol_start        = symbol_start_q;
    assign swap                = swap_q;
    assign idle                = empty_s & (state_q == ST_IDLE);
    assign line_x1             = line_x1_q;
    assign line_y1             = line_y1_q;
    assign line_x2             = line_x2_q;
    assign line_y2             = line_y2_q;
    assign symbol_x            = symbol_x_q;
    assign symbol_y            = symbol_y_q;
    assign symbol_symbol       = symbol_symbol_q;
    assign symbol_cursor_left  = symbol_cursor_left_q;
    assign symbol_cursor_right = symbol_cursor_right_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed testbench for draw_scheduler with behavioural drawer models
// (fill 5, line 3, symbol 4 busy cycles).
module tb_draw_scheduler;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int SW = 7;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [XW-1:0] cmd_x1 = '0, cmd_x2 = '0;
    logic [YW-1:0] cmd_y1 = '0, cmd_y2 = '0;
    logic [SW-1:0] cmd_symbol = '0;
    logic          cmd_cursor_left = 1'b0, cmd_cursor_right = 1'b0;
    logic          line_start, symbol_start, fill_start;
    logic          line_ready, symbol_ready, fill_ready;
    logic [XW-1:0] line_x1, line_x2, symbol_x;
    logic [YW-1:0] line_y1, line_y2, symbol_y;
    logic [SW-1:0] symbol_symbol;
    logic          symbol_cursor_left, symbol_cursor_right;
    logic          line_write_enable, symbol_write_enable, fill_write_enable;
    logic [AW-1:0] line_write_addr, symbol_write_addr, fill_write_addr;
    logic          line_write_data, symbol_write_data, fill_write_data;
    logic          fb_write_enable;
    logic [AW-1:0] fb_write_addr;
    logic          fb_write_data;
    logic          swap, idle, collision;

    // Drawer models and knobs
    logic fill_ready_r = 1'b1, line_ready_r = 1'b1, symbol_ready_r = 1'b1;
    int   fill_cnt_r = 0, line_cnt_r = 0, symbol_cnt_r = 0;
    logic line_hold = 1'b0;
    logic fill_wen_k = 1'b0, line_wen_k = 1'b0, sym_wen_k = 1'b0, sym_force = 1'b0;

    assign fill_ready          = fill_ready_r;
    assign line_ready          = line_ready_r & ~line_hold;
    assign symbol_ready        = symbol_ready_r;
    assign fill_write_enable   = fill_wen_k & ~fill_ready_r;
    assign fill_write_addr     = 19'h000AB;
    assign fill_write_data     = 1'b1;
    assign line_write_enable   = line_wen_k & ~line_ready_r;
    assign line_write_addr     = 19'h000CD;
    assign line_write_data     = 1'b1;
    assign symbol_write_enable = (sym_wen_k & ~symbol_ready_r) | sym_force;
    assign symbol_write_addr   = sym_force ? 19'h00123 : 19'h000EF;
    assign symbol_write_data   = 1'b1;

    always @(posedge clk) begin
        if (fill_start) begin fill_ready_r <= 1'b0; fill_cnt_r <= 4; end
        else if (!fill_ready_r) begin
            if (fill_cnt_r == 0) fill_ready_r <= 1'b1; else fill_cnt_r <= fill_cnt_r - 1;
        end
        if (line_start) begin line_ready_r <= 1'b0; line_cnt_r <= 2; end
        else if (!line_ready_r) begin
            if (line_cnt_r == 0) line_ready_r <= 1'b1; else line_cnt_r <= line_cnt_r - 1;
        end
        if (symbol_start) begin symbol_ready_r <= 1'b0; symbol_cnt_r <= 3; end
        else if (!symbol_ready_r) begin
            if (symbol_cnt_r == 0) symbol_ready_r <= 1'b1; else symbol_cnt_r <= symbol_cnt_r - 1;
        end
    end

    draw_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y1(cmd_y1), .cmd_y2(cmd_y2),
        .cmd_symbol(cmd_symbol), .cmd_cursor_left(cmd_cursor_left), .cmd_cursor_right(cmd_cursor_right),
        .line_start(line_start), .symbol_start(symbol_start), .fill_start(fill_start),
        .line_ready(line_ready), .symbol_ready(symbol_ready), .fill_ready(fill_ready),
        .line_x1(line_x1), .line_y1(line_y1), .line_x2(line_x2), .line_y2(line_y2),
        .symbol_x(symbol_x), .symbol_y(symbol_y), .symbol_symbol(symbol_symbol),
        .symbol_cursor_left(symbol_cursor_left), .symbol_cursor_right(symbol_cursor_right),
        .line_write_enable(line_write_enable), .line_write_addr(line_write_addr), .line_write_data(line_write_data),
        .symbol_write_enable(symbol_write_enable), .symbol_write_addr(symbol_write_addr), .symbol_write_data(symbol_write_data),
        .fill_write_enable(fill_write_enable), .fill_write_addr(fill_write_addr), .fill_write_data(fill_write_data),
        .fb_write_enable(fb_write_enable), .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
        .swap(swap), .idle(idle), .collision(collision)
    );

    // Event monitor: pulse counts and execution log (code = op*1024 + x)
    int   fill_starts = 0, line_starts = 0, symbol_starts = 0, swaps = 0;
    int   swap_early = 0, wide_starts = 0;
    int   log_q[$];
    logic pf = 1'b0, pl = 1'b0, ps = 1'b0;
    always @(negedge clk) begin
        if (fill_start) begin fill_starts <= fill_starts + 1; log_q.push_back(0); end
        if (line_start) begin line_starts <= line_starts + 1; log_q.push_back(1024 + int'(line_x1)); end
        if (symbol_start) begin symbol_starts <= symbol_starts + 1; log_q.push_back(2048 + int'(symbol_x)); end
        if (swap) begin
            swaps <= swaps + 1;
            log_q.push_back(3072);
            if (!(fill_ready && line_ready && symbol_ready)) swap_early <= swap_early + 1;
        end
        if ((fill_start && pf) || (line_start && pl) || (symbol_start && ps)) wide_starts <= wide_starts + 1;
        pf <= fill_start;
        pl <= line_start;
        ps <= symbol_start;
    end

    int n_checks = 0;
    int n_fails  = 0;

    function automatic logic sel(input int w);
        case (w)
            0:       return fill_start;
            1:       return line_start;
            2:       return symbol_start;
            3:       return swap;
            4:       return idle;
            5:       return fill_ready;
            6:       return line_ready;
            7:       return symbol_ready;
            8:       return fill_ready & line_ready & symbol_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (sel(w)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [1:0] op, input int x1, input int y1, input int x2, input int y2,
                        input int sym, input logic cl, input logic cr, output bit ok);
        cmd_valid = 1'b1; cmd_op = op;
        cmd_x1 = XW'(x1); cmd_y1 = YW'(y1); cmd_x2 = XW'(x2); cmd_y2 = YW'(y2);
        cmd_symbol = SW'(sym); cmd_cursor_left = cl; cmd_cursor_right = cr;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin @(negedge clk); ok = 1'b1; break; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        bit ok;
        wait_for(8, 100, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL reset_drain: drawers got busy expected idle"); end
        cmd_valid = 1'b0; line_hold = 1'b0; sym_force = 1'b0;
        fill_wen_k = 1'b0; line_wen_k = 1'b0; sym_wen_k = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({idle, cmd_ready, fb_write_enable} !== 3'b110) begin
            n_fails++; $display("FAIL reset_low_flags: got %b expected 110", {idle, cmd_ready, fb_write_enable});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fill_start, line_start, symbol_start, swap} !== 4'b0000) begin
            n_fails++; $display("FAIL reset_pulses: got %b expected 0000", {fill_start, line_start, symbol_start, swap});
        end
        n_checks++;
        if ({line_x1, line_y1, line_x2, line_y2, symbol_x, symbol_y, symbol_symbol} !== '0) begin
            n_fails++; $display("FAIL reset_args: got nonzero expected 0");
        end
        n_checks++;
        if (fb_write_addr !== 19'h0 || fb_write_data !== 1'b0 || collision !== 1'b0) begin
            n_fails++; $display("FAIL reset_fb: got addr %h coll %b expected 0 0", fb_write_addr, collision);
        end
        n_checks++;
        if (idle !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fails++; $display("FAIL reset_idle_ready: got %b%b expected 11", idle, cmd_ready);
        end
    endtask

    task automatic test_fill_swap();
        bit ok;
        int f0, s0, e0;
        do_reset();
        fill_wen_k = 1'b1;
        f0 = fill_starts; s0 = swaps; e0 = swap_early;
        push(2'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0, ok);
        push(2'd3, 0, 0, 0, 0, 0, 1'b0, 1'b0, ok);
        wait_for(0, 20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL fill_start_seen: got timeout expected pulse"); end
        @(negedge clk);
        n_checks++;
        if (fill_start !== 1'b0) begin n_fails++; $display("FAIL fill_start_width: got %b expected 0", fill_start); end
        n_checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 19'h000AB || fb_write_data !== 1'b1 || swap !== 1'b0) begin
            n_fails++; $display("FAIL fill_fb: got we %b addr %h swap %b expected 1 000ab 0", fb_write_enable, fb_write_addr, swap);
        end
        wait_for(5, 20, ok);
        wait_for(3, 10, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL fill_swap_seen: got timeout expected swap"); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (swaps - s0 !== 1 || fill_starts - f0 !== 1 || swap_early - e0 !== 0) begin
            n_fails++; $display("FAIL fill_swap_counts: got swaps %0d fills %0d early %0d expected 1 1 0",
                                swaps - s0, fill_starts - f0, swap_early - e0);
        end
        n_checks++;
        if (idle !== 1'b1 || fb_write_enable !== 1'b0) begin
            n_fails++; $display("FAIL fill_swap_idle: got idle %b we %b expected 1 0", idle, fb_write_enable);
        end
    endtask

    task automatic test_line();
        bit ok;
        int l0, bad;
        do_reset();
        l0 = line_starts; bad = 0;
        push(2'd1, 10, 20, 100, 200, 0, 1'b0, 1'b0, ok);
        wait_for(1, 20, ok);
        n_checks++;
        if (!ok || line_x1 !== 10'd10 || line_y1 !== 9'd20 || line_x2 !== 10'd100 || line_y2 !== 9'd200) begin
            n_fails++; $display("FAIL line_args: got %0d,%0d-%0d,%0d expected 10,20-100,200", line_x1, line_y1, line_x2, line_y2);
        end
        @(negedge clk);
        n_checks++;
        if (line_start !== 1'b0) begin n_fails++; $display("FAIL line_start_width: got %b expected 0", line_start); end
        for (int i = 0; i < 20 && !line_ready; i++) begin
            if (line_x1 !== 10'd10 || line_y1 !== 9'd20 || line_x2 !== 10'd100 || line_y2 !== 9'd200) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin n_fails++; $display("FAIL line_args_stable: got %0d bad cycles expected 0", bad); end
        wait_for(4, 20, ok);
        n_checks++;
        if (!ok || line_starts - l0 !== 1) begin
            n_fails++; $display("FAIL line_once: got %0d starts expected 1", line_starts - l0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        int ops[9] = '{1, 0, 2, 1, 0, 2, 3, 1, 2};
        int exp_code;
        do_reset();
        base = log_q.size();
        line_hold = 1'b1;
        push(2'd1, 1, 0, 0, 0, 0, 1'b0, 1'b0, ok);
        for (int i = 0; i < 8; i++) begin
            push(2'(ops[i]), 10 + i, 5, 0, 0, 0, 1'b0, 1'b0, ok);
            if (i == 6) begin
                n_checks++;
                if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_ready_after7: got %b expected 1", cmd_ready); end
            end
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_full_after8: got %b expected 0", cmd_ready); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0 || idle !== 1'b0) begin
            n_fails++; $display("FAIL b2b_stalled: got ready %b idle %b expected 0 0", cmd_ready, idle);
        end
        line_hold = 1'b0;
        push(2'(ops[8]), 18, 5, 0, 0, 0, 1'b0, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL b2b_ninth_push: got timeout expected accepted"); end
        @(negedge clk);
        wait_for(4, 400, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || log_q.size() - base !== 10) begin
            n_fails++; $display("FAIL b2b_count: got %0d events expected 10", log_q.size() - base);
        end else begin
            n_checks++;
            if (log_q[base] !== 1025) begin n_fails++; $display("FAIL b2b_order0: got %0d expected 1025", log_q[base]); end
            for (int i = 0; i < 9; i++) begin
                exp_code = (ops[i] == 3) ? 3072 : (ops[i] == 0) ? 0 : ops[i] * 1024 + 10 + i;
                n_checks++;
                if (log_q[base + 1 + i] !== exp_code) begin
                    n_fails++; $display("FAIL b2b_order%0d: got %0d expected %0d", i + 1, log_q[base + 1 + i], exp_code);
                end
            end
        end
    endtask

    task automatic test_collision();
        bit ok;
        logic exp_coll;
        do_reset();
`ifdef DRAW_SCHEDULER_COLLISION_EN
        exp_coll = 1'b1;
`else
        exp_coll = 1'b0;
`endif
        push(2'd1, 10, 20, 100, 200, 0, 1'b0, 1'b0, ok);
        wait_for(1, 20, ok);
        @(negedge clk);
        n_checks++;
        if (collision !== 1'b0) begin n_fails++; $display("FAIL coll_before: got %b expected 0", collision); end
        sym_force = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fb_write_enable !== 1'b0 || fb_write_addr !== 19'h000CD) begin
            n_fails++; $display("FAIL coll_masked: got we %b addr %h expected 0 000cd", fb_write_enable, fb_write_addr);
        end
        @(negedge clk);
        sym_force = 1'b0;
        n_checks++;
        if (collision !== exp_coll) begin n_fails++; $display("FAIL coll_flag: got %b expected %b", collision, exp_coll); end
        wait_for(4, 20, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (collision !== exp_coll) begin n_fails++; $display("FAIL coll_sticky: got %b expected %b", collision, exp_coll); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int f0, l0, s0, w0, leaks;
        do_reset();
        line_wen_k = 1'b1;
        push(2'd1, 3, 4, 5, 6, 0, 1'b0, 1'b0, ok);
        wait_for(1, 20, ok);
        @(negedge clk);
        n_checks++;
        if (fb_write_enable !== 1'b1) begin n_fails++; $display("FAIL rstmid_pre: got %b expected 1", fb_write_enable); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fb_write_enable !== 1'b0 || fb_write_addr !== 19'h0 || idle !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fails++; $display("FAIL rstmid_clear: got we %b addr %h idle %b ready %b expected 0 0 1 1",
                                fb_write_enable, fb_write_addr, idle, cmd_ready);
        end
        rst_n = 1'b1;
        f0 = fill_starts; l0 = line_starts; s0 = symbol_starts; w0 = swaps; leaks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fb_write_enable !== 1'b0) leaks++;
        end
        n_checks++;
        if (leaks !== 0 || fill_starts - f0 + line_starts - l0 + symbol_starts - s0 + swaps - w0 !== 0) begin
            n_fails++; $display("FAIL rstmid_quiet: got %0d leaks %0d pulses expected 0 0", leaks,
                                fill_starts - f0 + line_starts - l0 + symbol_starts - s0 + swaps - w0);
        end
    endtask

    task automatic test_symbol_swap();
        bit ok;
        int s0, e0, early;
        do_reset();
        sym_wen_k = 1'b1;
        s0 = swaps; e0 = swap_early; early = 0;
        push(2'd2, 8, 4, 0, 0, 8'h31, 1'b1, 1'b0, ok);
        push(2'd3, 0, 0, 0, 0, 0, 1'b0, 1'b0, ok);
        wait_for(2, 20, ok);
        n_checks++;
        if (!ok || symbol_x !== 10'd8 || symbol_y !== 9'd4 || symbol_symbol !== 7'h31) begin
            n_fails++; $display("FAIL sym_args: got %0d,%0d code %h expected 8,4 31", symbol_x, symbol_y, symbol_symbol);
        end
        n_checks++;
        if (symbol_cursor_left !== 1'b1 || symbol_cursor_right !== 1'b0) begin
            n_fails++; $display("FAIL sym_cursor: got %b%b expected 10", symbol_cursor_left, symbol_cursor_right);
        end
        @(negedge clk);
        for (int i = 0; i < 20 && !symbol_ready; i++) begin
            if (swap !== 1'b0) early++;
            @(negedge clk);
        end
        n_checks++;
        if (early !== 0) begin n_fails++; $display("FAIL sym_swap_early: got %0d expected 0", early); end
        wait_for(3, 10, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || swaps - s0 !== 1 || swap_early - e0 !== 0 || idle !== 1'b1) begin
            n_fails++; $display("FAIL sym_swap: got swaps %0d early %0d idle %b expected 1 0 1",
                                swaps - s0, swap_early - e0, idle);
        end
    endtask

    task automatic test_pulse_width();
        n_checks++;
        if (wide_starts !== 0) begin n_fails++; $display("FAIL start_width_all: got %0d expected 0", wide_starts); end
    endtask

    initial begin
        test_reset();
        test_fill_swap();
        test_line();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_symbol_swap();
        test_pulse_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
